// File: rtl/lzs_job_pkg.sv
// lzs_job_pkg: shared constants for the LZS job sequencer.
// State encodings, status codes and descriptor/capability bit positions.
package lzs_job_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_PRERST = 3'd1;
   localparam logic [2:0] ST_RUN    = 3'd2;
   localparam logic [2:0] ST_FLUSH  = 3'd3;
   localparam logic [2:0] ST_REPORT = 3'd4;

   localparam logic [1:0] STS_OK      = 2'd0;
   localparam logic [1:0] STS_BADOP   = 2'd1;
   localparam logic [1:0] STS_TIMEOUT = 2'd2;
   localparam logic [1:0] STS_ABORT   = 2'd3;

   localparam int unsigned DC_ENC  = 5;
   localparam int unsigned DC_DEC  = 6;
   localparam int unsigned CAP_ENC = 6;
   localparam int unsigned CAP_DEC = 7;

   // A job is runnable when exactly one operation is requested and the
   // datapath advertises that operation.
   function automatic logic op_valid(input logic enc, input logic dec,
                                     input logic cap_enc, input logic cap_dec);
      return (enc ^ dec) && (enc ? cap_enc : cap_dec);
   endfunction

endpackage

// File: rtl/lzs_job_cnt.sv
// lzs_job_cnt: saturating run-cycle counter, reset-phase down-counter and
// watchdog compare for lzs_job_ctrl.
// Optional feature macro: LZS_JOB_WATCHDOG_EN (watchdog comparator present).
import lzs_job_pkg::*;

module lzs_job_cnt #(
   parameter int unsigned CW = 24
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          cyc_clr_i,
   input  logic          cyc_inc_i,
   input  logic          dn_load_i,
   input  logic [3:0]    dn_val_i,
   input  logic [CW-1:0] wd_limit_i,
   output logic [CW-1:0] cyc_nxt_o,
   output logic          dn_zero_o,
   output logic          wd_hit_o
);

   logic [CW-1:0] cyc_q, cyc_d;
   logic [3:0]    dn_q, dn_d;

   // Next-state for the run-cycle counter (clear wins, saturates at all-ones)
   always_comb begin
      cyc_d = cyc_q;
      if (cyc_clr_i) begin
         cyc_d = '0;
      end else if (cyc_inc_i && (cyc_q != '1)) begin
         cyc_d = cyc_q + CW'(1);
      end
   end

   // Next-state for the reset-phase down-counter (stops at zero)
   always_comb begin
      dn_d = dn_q;
      if (dn_load_i) begin
         dn_d = dn_val_i;
      end else if (dn_q != '0) begin
         dn_d = dn_q - 4'd1;
      end
   end

   // Counter registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cyc_q <= '0;
         dn_q  <= '0;
      end else begin
         cyc_q <= cyc_d;
         dn_q  <= dn_d;
      end
   end

   assign cyc_nxt_o = cyc_d;
   assign dn_zero_o = (dn_q == '0);

`ifdef LZS_JOB_WATCHDOG_EN
   // Compare against the post-increment count so the limit cycle itself trips
   assign wd_hit_o = (wd_limit_i != '0) && (cyc_d >= wd_limit_i);
`else
   logic unused_wd_limit;
   assign unused_wd_limit = ^wd_limit_i;
   assign wd_hit_o        = 1'b0;
`endif

endmodule

// File: rtl/lzs_job_ctrl.sv
// lzs_job_ctrl: job sequencer for the LZS compression/decompression datapath.
// Accepts a descriptor, checks it against the capability byte, brackets the
// job with datapath reset, and returns tag/code/run-cycle status.
// Optional feature macro: LZS_JOB_WATCHDOG_EN (watchdog TIMEOUT path).
import lzs_job_pkg::*;

module lzs_job_ctrl #(
   parameter int unsigned RST_CYCLES = 4,
   parameter int unsigned CW         = 24
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [23:0]   cmd_dc,
   input  logic [7:0]    cmd_tag,
   output logic          sts_valid,
   input  logic          sts_ready,
   output logic [7:0]    sts_tag,
   output logic [1:0]    sts_code,
   output logic [CW-1:0] sts_cycles,
   input  logic          abort,
   input  logic [CW-1:0] wd_limit,
   input  logic [7:0]    m_cap,
   input  logic          m_endn,
   output logic          m_reset,
   output logic          m_enable,
   output logic [23:0]   dc
);

   logic [2:0]    state_q, state_d;
   logic [1:0]    code_q, code_d;
   logic [7:0]    tag_q, tag_d;
   logic [23:0]   dc_q, dc_d;
   logic          cmd_ready_q, sts_valid_q, m_reset_q, m_enable_q;
   logic [7:0]    sts_tag_q;
   logic [1:0]    sts_code_q;
   logic [CW-1:0] sts_cycles_q;

   logic          cyc_clr, cyc_inc, dn_load, dn_zero, wd_hit;
   logic [3:0]    dn_val;
   logic [CW-1:0] cyc_nxt;
   logic          op_ok, enter_report;

   logic unused_cap;
   assign unused_cap = ^m_cap[5:0];

   assign op_ok = op_valid(cmd_dc[DC_ENC], cmd_dc[DC_DEC], m_cap[CAP_ENC], m_cap[CAP_DEC]);

   lzs_job_cnt #(.CW(CW)) u_cnt (
      .clk_i      (wb_clk_i),
      .rst_i      (wb_rst_i),
      .cyc_clr_i  (cyc_clr),
      .cyc_inc_i  (cyc_inc),
      .dn_load_i  (dn_load),
      .dn_val_i   (dn_val),
      .wd_limit_i (wd_limit),
      .cyc_nxt_o  (cyc_nxt),
      .dn_zero_o  (dn_zero),
      .wd_hit_o   (wd_hit)
   );

   // Job sequencing: next state, status code and counter controls.
   // PRERST is loaded with RST_CYCLES (the accept cycle is not counted) while
   // FLUSH is loaded with RST_CYCLES-1 since its entry cycle already holds reset.
   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      tag_d   = tag_q;
      dc_d    = dc_q;
      cyc_clr = 1'b0;
      cyc_inc = 1'b0;
      dn_load = 1'b0;
      dn_val  = '0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               dc_d    = cmd_dc;
               tag_d   = cmd_tag;
               cyc_clr = 1'b1;
               if (op_ok) begin
                  state_d = ST_PRERST;
                  dn_load = 1'b1;
                  dn_val  = 4'(RST_CYCLES);
               end else begin
                  state_d = ST_REPORT;
                  code_d  = STS_BADOP;
               end
            end
         end
         ST_PRERST: begin
            if (abort) begin
               state_d = ST_REPORT;
               code_d  = STS_ABORT;
            end else if (dn_zero) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            cyc_inc = 1'b1;
            if (!m_endn) begin
               state_d = ST_REPORT;
               code_d  = STS_OK;
            end else if (abort || wd_hit) begin
               state_d = ST_FLUSH;
               code_d  = abort ? STS_ABORT : STS_TIMEOUT;
               dn_load = 1'b1;
               dn_val  = 4'(RST_CYCLES - 1);
            end
         end
         ST_FLUSH: begin
            if (dn_zero) begin
               state_d = ST_REPORT;
            end
         end
         ST_REPORT: begin
            if (sts_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign enter_report = (state_d == ST_REPORT) && (state_q != ST_REPORT);

   // State, job context and registered outputs
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q      <= ST_IDLE;
         code_q       <= STS_OK;
         tag_q        <= '0;
         dc_q         <= '0;
         cmd_ready_q  <= 1'b1;
         sts_valid_q  <= 1'b0;
         m_reset_q    <= 1'b1;
         m_enable_q   <= 1'b0;
         sts_tag_q    <= '0;
         sts_code_q   <= '0;
         sts_cycles_q <= '0;
      end else begin
         state_q     <= state_d;
         code_q      <= code_d;
         tag_q       <= tag_d;
         dc_q        <= dc_d;
         cmd_ready_q <= (state_d == ST_IDLE);
         sts_valid_q <= (state_d == ST_REPORT);
         m_reset_q   <= (state_d != ST_RUN);
         m_enable_q  <= (state_d == ST_RUN);
         if (enter_report) begin
            sts_tag_q    <= tag_d;
            sts_code_q   <= code_d;
            sts_cycles_q <= cyc_nxt;
         end
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign sts_valid  = sts_valid_q;
   assign sts_tag    = sts_tag_q;
   assign sts_code   = sts_code_q;
   assign sts_cycles = sts_cycles_q;
   assign m_reset    = m_reset_q;
   assign m_enable   = m_enable_q;
   assign dc         = dc_q;

endmodule

// File: tb/tb_lzs_job_ctrl.sv
// tb_lzs_job_ctrl: directed and randomized jobs checked against a
// job-level reference model (earliest event wins, ties OK > ABORT > TIMEOUT).
module tb_lzs_job_ctrl;

   localparam int R  = 4;
   localparam int CW = 24;
`ifdef LZS_JOB_WATCHDOG_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          wb_rst_i = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [23:0]   cmd_dc = '0;
   logic [7:0]    cmd_tag = '0;
   logic          sts_valid;
   logic          sts_ready = 1'b0;
   logic [7:0]    sts_tag;
   logic [1:0]    sts_code;
   logic [CW-1:0] sts_cycles;
   logic          abort = 1'b0;
   logic [CW-1:0] wd_limit = '0;
   logic [7:0]    m_cap = 8'hC0;
   logic          m_endn = 1'b1;
   logic          m_reset;
   logic          m_enable;
   logic [23:0]   dc;

   int errors = 0;
   int checks = 0;

   lzs_job_ctrl #(.RST_CYCLES(R), .CW(CW)) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (wb_rst_i),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_dc    (cmd_dc),
      .cmd_tag   (cmd_tag),
      .sts_valid (sts_valid),
      .sts_ready (sts_ready),
      .sts_tag   (sts_tag),
      .sts_code  (sts_code),
      .sts_cycles(sts_cycles),
      .abort     (abort),
      .wd_limit  (wd_limit),
      .m_cap     (m_cap),
      .m_endn    (m_endn),
      .m_reset   (m_reset),
      .m_enable  (m_enable),
      .dc        (dc)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Job-level reference: endk/abk/wd are 1-based RUN cycles (0 = never).
   function automatic void model(input logic [23:0] d, input logic [7:0] cap,
                                 input int endk, input int abk, input int wd,
                                 output int code, output int cyc, output int fl);
      logic enc, dec;
      enc = d[5];
      dec = d[6];
      fl  = 0;
      if ((enc == dec) || (enc && !cap[6]) || (dec && !cap[7])) begin
         code = 1;
         cyc  = 0;
         return;
      end
      cyc  = 1 << 30;
      code = 0;
      if (endk > 0) cyc = endk;
      if (abk > 0 && abk < cyc) begin cyc = abk; code = 3; end
      if (WD_EN && wd > 0 && wd < cyc) begin cyc = wd; code = 2; end
      if (code != 0) fl = R;
   endfunction

   task automatic run_job(input logic [23:0] d, input logic [7:0] cap, input logic [7:0] tg,
                          input int endk, input int abk, input int wd, input int hold);
      int  ecode, ecyc, efl, n, r;
      bit  ok;
      model(d, cap, endk, abk, wd, ecode, ecyc, efl);
      m_cap     = cap;
      wd_limit  = CW'(wd);
      cmd_dc    = d;
      cmd_tag   = tg;
      cmd_valid = 1'b1;
      chk("cmd_ready_idle", {31'd0, cmd_ready}, 1);
      @(posedge clk); @(negedge clk);
      cmd_valid = 1'b0;
      cmd_dc    = 24'($urandom);
      cmd_tag   = 8'($urandom);
      chk("dc_latched", {8'd0, dc}, {8'd0, d});
      chk("cmd_ready_busy", {31'd0, cmd_ready}, 0);
      if (ecode == 1) begin
         chk("badop_sts_valid", {31'd0, sts_valid}, 1);
         chk("badop_no_enable", {31'd0, m_enable}, 0);
      end else begin
         n  = 0;
         ok = 1'b1;
         while (!m_enable && n < 50) begin
            if (!m_reset || sts_valid) ok = 1'b0;
            @(posedge clk); @(negedge clk);
            n++;
         end
         chk("prerst_len", n, R + 1);
         chk("prerst_reset_held", {31'd0, ok}, 1);
         r = 0;
         while (m_enable && r < 400) begin
            r++;
            m_endn = (r == endk) ? 1'b0 : 1'b1;
            abort  = (r == abk) ? 1'b1 : 1'b0;
            @(posedge clk); @(negedge clk);
         end
         m_endn = 1'b1;
         abort  = 1'b0;
         chk("run_len", r, ecyc);
         n  = 0;
         ok = 1'b1;
         while (!sts_valid && n < 50) begin
            if (!m_reset || m_enable) ok = 1'b0;
            @(posedge clk); @(negedge clk);
            n++;
         end
         chk("flush_len", n, efl);
         chk("flush_reset_held", {31'd0, ok}, 1);
      end
      chk("sts_tag", {24'd0, sts_tag}, {24'd0, tg});
      chk("sts_code", {30'd0, sts_code}, ecode);
      chk("sts_cycles", {8'd0, sts_cycles}, ecyc);
      if (hold > 0) begin
         ok = 1'b1;
         for (int h = 0; h < hold; h++) begin
            @(posedge clk); @(negedge clk);
            if (sts_valid !== 1'b1 || sts_tag !== tg || sts_code !== 2'(ecode) ||
                sts_cycles !== CW'(ecyc) || cmd_ready !== 1'b0 || m_enable !== 1'b0 ||
                m_reset !== 1'b1)
               ok = 1'b0;
         end
         chk("backpressure_stable", {31'd0, ok}, 1);
      end
      sts_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      sts_ready = 1'b0;
      chk("post_hs_sts_valid", {31'd0, sts_valid}, 0);
      chk("post_hs_cmd_ready", {31'd0, cmd_ready}, 1);
   endtask

   initial begin
      int  n;
      bit  ok;
      logic [23:0] d;
      logic [23:0] op;
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 1);
      chk("rst_sts_valid", {31'd0, sts_valid}, 0);
      chk("rst_m_reset", {31'd0, m_reset}, 1);
      chk("rst_m_enable", {31'd0, m_enable}, 0);
      chk("rst_dc", {8'd0, dc}, 0);
      chk("rst_sts_fields", {sts_tag, sts_code, 22'd0}, 0);
      chk("rst_sts_cycles", {8'd0, sts_cycles}, 0);
      wb_rst_i = 1'b0;
      @(negedge clk);

      // Encode job, end 100 cycles after enable
      run_job(24'h000020, 8'hC0, 8'h11, 101, 0, 0, 0);
      // Decode job
      run_job(24'h000040, 8'hC0, 8'h22, 7, 0, 0, 0);
      // Operation check failures
      run_job(24'h000060, 8'hC0, 8'h33, 5, 0, 0, 0);
      run_job(24'h000000, 8'hC0, 8'h34, 5, 0, 0, 0);
      run_job(24'h000040, 8'h40, 8'h35, 5, 0, 0, 0);
      // Watchdog (OK at 80 when the watchdog is compiled out)
      run_job(24'h000020, 8'hC0, 8'h44, 80, 0, 50, 0);
      // Abort in RUN; abort coinciding with end
      run_job(24'h000040, 8'h80, 8'h55, 60, 10, 0, 0);
      run_job(24'h000020, 8'h40, 8'h56, 15, 15, 0, 0);
      // Back-pressure, then back-to-back second job
      run_job(24'h000020, 8'hC0, 8'h66, 5, 0, 0, 20);
      run_job(24'h000040, 8'hC0, 8'h67, 3, 0, 0, 0);

      // Abort during PRERST
      cmd_dc = 24'h000020; m_cap = 8'hC0; cmd_tag = 8'h77; wd_limit = '0; cmd_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      cmd_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      abort = 1'b1;
      @(posedge clk); @(negedge clk);
      abort = 1'b0;
      chk("preabort_sts_valid", {31'd0, sts_valid}, 1);
      chk("preabort_code", {30'd0, sts_code}, 3);
      chk("preabort_cycles", {8'd0, sts_cycles}, 0);
      chk("preabort_tag", {24'd0, sts_tag}, 8'h77);
      chk("preabort_no_enable", {31'd0, m_enable}, 0);
      sts_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      sts_ready = 1'b0;

      // Asynchronous reset mid-RUN
      cmd_dc = 24'h000020; cmd_tag = 8'h88; cmd_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      cmd_valid = 1'b0;
      n = 0;
      while (!m_enable && n < 50) begin
         @(posedge clk); @(negedge clk);
         n++;
      end
      chk("midrst_enabled", {31'd0, m_enable}, 1);
      repeat (10) @(negedge clk);
      #2 wb_rst_i = 1'b1;
      #1;
      chk("midrst_m_enable", {31'd0, m_enable}, 0);
      chk("midrst_m_reset", {31'd0, m_reset}, 1);
      chk("midrst_dc", {8'd0, dc}, 0);
      chk("midrst_cmd_ready", {31'd0, cmd_ready}, 1);
      @(negedge clk);
      wb_rst_i = 1'b0;
      ok = 1'b1;
      repeat (5) begin
         @(posedge clk); @(negedge clk);
         if (sts_valid !== 1'b0 || cmd_ready !== 1'b1 || m_enable !== 1'b0) ok = 1'b0;
      end
      chk("midrst_job_lost", {31'd0, ok}, 1);

      // Randomized jobs
      for (int i = 0; i < 14; i++) begin
         case ($urandom_range(0, 4))
            0: op = 24'h000020;
            1: op = 24'h000040;
            2: op = 24'h000060;
            3: op = 24'h000000;
            default: op = 24'h000020;
         endcase
         d = (24'($urandom) & 24'hFFFF9F) | op;
         run_job(d, {2'($urandom_range(0, 3)), 6'($urandom)}, 8'($urandom),
                 $urandom_range(1, 40),
                 ($urandom_range(0, 1) == 1) ? $urandom_range(1, 40) : 0,
                 ($urandom_range(0, 1) == 1) ? $urandom_range(1, 45) : 0,
                 ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lzs_job_ctrl.md
# lzs_job_ctrl

Job sequencer in front of the compression/decompression datapath (copy/encode/decode/codeout cluster). It accepts one job descriptor at a time from the host command queue and checks the requested operation against the datapath capability byte. It brackets each job with a datapath reset, holds the datapath enable for the job's duration, and detects end-of-job from the active-low end strobe. It then returns a status record (tag, result code, run-cycle count) to the host side.

## Interface
- RST_CYCLES, 4: minimum cycles m_reset is held before each job; legal range 1..15.
- CW, 24: width of the run-cycle counter and of the watchdog limit.
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset; asynchronous, active-high
- cmd_valid  in  1  descriptor offered
- cmd_ready  out  1  descriptor accepted when both are high
- cmd_dc  in  24  descriptor; bit 5 = encode, bit 6 = decode
- cmd_tag  in  8  job tag, echoed in status
- sts_valid  out  1  status record offered
- sts_ready  in  1  status record consumed when both are high
- sts_tag  out  8  tag of the finished job
- sts_code  out  2  0 OK, 1 BADOP, 2 TIMEOUT, 3 ABORT
- sts_cycles  out  CW  RUN cycles, saturating
- abort  in  1  single-cycle abort request
- wd_limit  in  CW  watchdog limit; 0 disables the watchdog
- m_cap  in  8  datapath capability; bit 6 = encode, bit 7 = decode
- m_endn  in  1  datapath end-of-job, active-low
- m_reset  out  1  datapath reset, active-high
- m_enable  out  1  datapath enable
- dc  out  24  registered descriptor to the datapath

## Operation
- States: IDLE, PRERST, RUN, FLUSH, REPORT.
- IDLE: cmd_ready=1. On accept, latch cmd_dc and cmd_tag, clear the cycle counter, then apply the operation check.
  - Valid operation: exactly one of dc[5] or dc[6] is set, and the matching m_cap bit is 1.
  - Invalid operation: go to REPORT with BADOP. The datapath is never enabled.
  - Valid operation: go to PRERST.
- PRERST: m_reset=1. Count RST_CYCLES cycles, then go to RUN.
- RUN: m_reset=0, m_enable=1. The cycle counter increments every RUN cycle and saturates at all-ones.
  - m_endn low: go to REPORT with OK.
  - Watchdog: if wd_limit≠0 and the counter reaches wd_limit, go to FLUSH with TIMEOUT.
  - Abort: if abort=1, go to FLUSH with ABORT.
- FLUSH: m_reset=1, m_enable=0 for RST_CYCLES cycles, then go to REPORT.
- REPORT: sts_valid=1, holding stable values. On sts_ready, go to IDLE.
- m_reset=1 in every state except RUN, so the datapath is held in reset while idle.
- dc holds the last accepted descriptor. It updates only on accept.
- m_endn is ignored outside RUN.
- abort is ignored in IDLE, FLUSH and REPORT.
- In PRERST, abort goes directly to REPORT with ABORT; the datapath is already in reset.

## Timing
- Reset values: cmd_ready=1, sts_valid=0, sts_tag=0, sts_code=0, sts_cycles=0, m_reset=1, m_enable=0, dc=0; state is IDLE.
- All outputs are registered.
- Accept at edge N: m_reset stays high for edges N+1..N+RST_CYCLES; m_enable=1 from edge N+RST_CYCLES+1.
- m_endn sampled low at edge E: m_enable=0 and m_reset=1 after E, sts_valid=1 after E. Cycle count includes the E cycle.
- Simultaneous events in RUN, highest priority first: m_endn low (OK), then abort, then watchdog.
- BADOP: sts_valid=1 one cycle after accept.
- Back-to-back jobs: the earliest next cmd_ready is the cycle after the status handshake.
- Asynchronous reset mid-job: all state and outputs return to reset values immediately, and the job is lost without status.

## Configuration
- LZS_JOB_WATCHDOG_EN
  - Defined: watchdog comparator and TIMEOUT path are present.
  - Undefined: wd_limit is ignored, TIMEOUT is never produced, and the counter still runs for sts_cycles.

## Structure
- Package lzs_job_pkg holds:
  - state encoding constants;
  - status code constants STS_OK/STS_BADOP/STS_TIMEOUT/STS_ABORT;
  - descriptor bit positions DC_ENC=5 and DC_DEC=6;
  - capability bit positions CAP_ENC=6 and CAP_DEC=7.
- One sub-module, lzs_job_cnt: the shared saturating cycle counter, plus the PRERST/FLUSH down-counter and the watchdog compare.

## Test plan
- Encode job: dc=0x000020, m_cap=0xC0, m_endn low 100 cycles after enable -> m_reset high for 4 cycles, then m_enable; sts_code=0, sts_cycles=101, tag echoed.
- Operation check: dc=0x000060 (both bits), dc=0x000000, and dc=0x000040 with m_cap=0x40 -> BADOP each time; m_enable never rises.
- Watchdog (macro defined): wd_limit=50, m_endn held high -> TIMEOUT, sts_cycles=50, m_reset high for 4 cycles before sts_valid. Macro undefined: job runs until m_endn low.
- Abort: pulse abort in RUN, and separately in PRERST -> ABORT status; abort in the same cycle as m_endn low gives OK.
- Back-pressure: sts_ready held low for 20 cycles -> status fields stable, cmd_ready=0; a second job is accepted the cycle after the handshake.
- Reset mid-RUN: assert wb_rst_i -> m_enable=0 and m_reset=1 immediately, no sts_valid, cmd_ready=1 after release.
